icache_dm_refill: RTL and testbench
===================================

// Module: icache_dm_refill
// PURPOSE
//  Parametrised direct-mapped instruction cache for the fetch stage; next generation of the fixed 64-set/4-word fetch cache.
//  Adds a real miss FSM with valid/ready handshakes on both sides, width/depth parameters, a flush, and optional perf counters.
//  Sits between PC/fetch logic (CPU side) and the instruction memory / bus (line-refill side).
// PARAMETERS
//  ADDR_W          32  word-address width of req_addr
//  DATA_W          32  instruction word width
//  WORDS_PER_LINE  4   words per line; power of 2, >=2; OFF_W=log2
//  SETS            64  number of lines; power of 2; IDX_W=log2; TAG_W=ADDR_W-IDX_W-OFF_W
// PORTS
//  clk             in   1                      clock
//  rst             in   1                      synchronous, active-high reset
//  req_valid       in   1                      CPU fetch request
//  req_addr        in   ADDR_W                 word address: [OFF_W-1:0] offset, next IDX_W index, rest tag
//  req_ready       out  1                      cache can accept a request this cycle
//  resp_valid      out  1                      instruction valid (1-cycle pulse)
//  resp_instr      out  DATA_W                 fetched instruction
//  flush           in   1                      invalidate all lines
//  mem_req_valid   out  1                      line refill request
//  mem_req_addr    out  ADDR_W                 line-aligned word address (offset bits 0)
//  mem_req_ready   in   1                      memory accepts refill request
//  mem_resp_valid  in   1                      refill line data valid
//  mem_resp_data   in   DATA_W*WORDS_PER_LINE  line; word k at [k*DATA_W +: DATA_W]
// BEHAVIOUR
//  Storage: per set, valid flop + TAG_W tag + line data; valid bits cleared by rst and flush; data/tag not reset.
//  FSM: IDLE -> LOOKUP -> (hit) IDLE | (miss) MEM_REQ -> MEM_WAIT -> REFILL -> IDLE.
//  req_ready = (state==IDLE) && !flush. Request accepted when req_valid && req_ready; address captured in a register.
//  LOOKUP (cycle N+1 after accept N): compare valid && tag on captured index.
//   hit: resp_valid=1, resp_instr=word[offset] in this same cycle; next state IDLE. Hit latency = 1 cycle.
//   miss: next state MEM_REQ.
//  MEM_REQ: mem_req_valid=1, mem_req_addr={tag,index,0}; both stable until mem_req_ready; then MEM_WAIT.
//  MEM_WAIT: on mem_resp_valid write whole line, set tag, set valid; -> REFILL. mem_resp_valid outside MEM_WAIT ignored.
//  REFILL: resp_valid=1, resp_instr=word[offset] from the newly written line; -> IDLE.
//  Miss latency = 3 cycles + request-handshake wait + response wait (min 4 cycles from accept to resp_valid).
//  Eviction: a miss overwrites the set unconditionally (read-only cache, no write-back).
//  resp_valid and mem_req_valid are 0 in every other state; resp_instr holds its last value when resp_valid=0.
//  flush in IDLE/LOOKUP: all valid bits cleared at that edge; in LOOKUP, flush takes priority: reported as miss
//   only if tag check already failed; a hit still responds (data read before clear).
//  flush during MEM_REQ/MEM_WAIT/REFILL: latched as pending; applied on the REFILL->IDLE edge, after the response,
//   so the refilled line ends invalid. req_ready stays 0 while flush or pending flush is high.
//  rst: state=IDLE, all valid=0, resp_valid=0, resp_instr=0, mem_req_valid=0, mem_req_addr=0, pending flush=0;
//   rst mid-miss abandons the refill; later mem_resp_valid is ignored (FSM in IDLE).
//  Back-to-back: new request accepted the cycle after return to IDLE (one bubble per access).
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: adds outputs hit_count[31:0], miss_count[31:0]; increment on LOOKUP hit / LOOKUP miss,
//   saturate at 32'hFFFF_FFFF, cleared by rst only (not flush).
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Cold miss: rst, req addr 0x10, mem_req_ready=1, resp after 2 cycles with line {D,C,B,A} -> mem_req_addr=0x10, resp_instr=A.
//  Hit: then req 0x13 -> resp_valid at N+1, resp_instr=D, mem_req_valid stays 0.
//  Conflict: req 0x110 (same index, new tag) -> miss, mem_req_addr=0x110; re-req 0x10 -> misses again.
//  Backpressure: mem_req_ready low 5 cycles -> mem_req_valid/addr held stable, no resp until handshake.
//  Flush mid-miss: flush in MEM_WAIT -> response still delivered; next req same addr misses; req_ready 0 meanwhile.
//  Reset mid-miss + perf: rst in MEM_WAIT, late mem_resp_valid -> no resp, no valid set; counters read 0 (if EN).

Source files
------------

// File: rtl/icache_dm_refill.sv
// Direct-mapped fetch cache with a blocking line-refill miss FSM.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_CNT_EN.
module icache_dm_refill #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS           = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  input  logic [ADDR_W-1:0]                req_addr,
  output logic                             req_ready,
  output logic                             resp_valid,
  output logic [DATA_W-1:0]                resp_instr,
  input  logic                             flush,
  output logic                             mem_req_valid,
  output logic [ADDR_W-1:0]                mem_req_addr,
  input  logic                             mem_req_ready,
  input  logic                             mem_resp_valid,
  input  logic [DATA_W*WORDS_PER_LINE-1:0] mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]                      hit_count,
  output logic [31:0]                      miss_count
`endif
);

  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_REFILL
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] instr_q;
  logic              pend_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_mem [SETS];
  logic [LINE_W-1:0] data_mem [SETS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [LINE_W-1:0] line_rd;
  logic [DATA_W-1:0] word_rd;
  logic              hit;
  logic              fill;
  logic              clr_valid;

  assign off     = addr_q[OFF_W-1:0];
  assign idx     = addr_q[OFF_W +: IDX_W];
  assign tag     = addr_q[ADDR_W-1 -: TAG_W];
  assign line_rd = data_mem[idx];
  assign word_rd = line_rd[int'(off)*DATA_W +: DATA_W];
  assign hit     = valid_q[idx] && (tag_mem[idx] == tag);
  assign fill    = (state_q == S_MEM_WAIT) && mem_resp_valid;

  // A flush seen mid-miss only lands once the refill has been answered.
  assign clr_valid =
    (flush && (state_q == S_IDLE || state_q == S_LOOKUP)) ||
    ((state_q == S_REFILL) && (pend_q || flush));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (req_valid && req_ready) state_d = S_LOOKUP;
      S_LOOKUP:   state_d = hit ? S_IDLE : S_MEM_REQ;
      S_MEM_REQ:  if (mem_req_ready) state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (mem_resp_valid) state_d = S_REFILL;
      S_REFILL:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state_q == S_IDLE) && !flush && !pend_q;
    resp_valid    = ((state_q == S_LOOKUP) && hit) ||
                    (state_q == S_REFILL);
    mem_req_valid = (state_q == S_MEM_REQ);
    mem_req_addr  = '0;
    if (state_q == S_MEM_REQ)
      mem_req_addr = {tag, idx, {OFF_W{1'b0}}};
    resp_instr    = resp_valid ? word_rd : instr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      instr_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      if (req_valid && req_ready) addr_q <= req_addr;
      if (resp_valid) instr_q <= word_rd;
      if (state_q == S_REFILL)
        pend_q <= 1'b0;
      else if (flush && (state_q == S_MEM_REQ ||
                         state_q == S_MEM_WAIT))
        pend_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_valid) valid_q <= '0;
    else if (fill)        valid_q[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= mem_resp_data;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == S_LOOKUP) begin
      if (hit && hit_q != 32'hFFFF_FFFF)
        hit_q <= hit_q + 32'd1;
      if (!hit && miss_q != 32'hFFFF_FFFF)
        miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_icache_dm_refill.sv
// Directed bench for icache_dm_refill: miss, hit, conflict,
// backpressure, flush mid-miss and reset mid-miss.
module tb_icache_dm_refill;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_instr;
  logic         flush;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] LINE1 =
    {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [127:0] LINE2 =
    {32'h4444000D, 32'h3333000C, 32'h2222000B, 32'h1111000A};
  localparam logic [127:0] LINE3 =
    {32'h90000003, 32'h90000002, 32'h90000001, 32'h90000000};
  localparam logic [127:0] LINE4 =
    {32'h70000003, 32'h70000002, 32'h70000001, 32'h70000000};

  icache_dm_refill dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_instr     (resp_instr),
    .flush          (flush),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string t, input logic [127:0] o,
                     input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic do_miss(input logic [31:0] a,
                         input logic [127:0] line,
                         input logic [31:0] exp, input string t);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    #1;
    chk({t, "_lookup_rv"}, resp_valid, 0);
    tick();
    #1;
    chk({t, "_mreq_v"}, mem_req_valid, 1);
    chk({t, "_mreq_a"}, mem_req_addr, a & ~32'h3);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = line;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk({t, "_refill_rv"}, resp_valid, 1);
    chk({t, "_refill_ins"}, resp_instr, exp);
    tick();
    #1;
    chk({t, "_idle_rv"}, resp_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    flush = 1'b0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_rv", resp_valid, 0);
    chk("rst_ins", resp_instr, 0);
    chk("rst_mreq_v", mem_req_valid, 0);
    chk("rst_mreq_a", mem_req_addr, 0);

    // cold miss, response two cycles into MEM_WAIT
    req_valid = 1'b1;
    req_addr = 32'h10;
    tick();
    req_valid = 1'b0;
    #1;
    chk("cold_lookup_rv", resp_valid, 0);
    chk("cold_lookup_rdy", req_ready, 0);
    tick();
    chk("cold_mreq_v", mem_req_valid, 1);
    chk("cold_mreq_a", mem_req_addr, 32'h10);
    tick();
    chk("cold_wait_mreq_v", mem_req_valid, 0);
    chk("cold_wait_rv", resp_valid, 0);
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data = LINE1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("cold_refill_rv", resp_valid, 1);
    chk("cold_refill_ins", resp_instr, 32'hAAAA0000);
    tick();
    chk("cold_idle_rv", resp_valid, 0);
    chk("cold_hold_ins", resp_instr, 32'hAAAA0000);
    chk("cold_idle_rdy", req_ready, 1);

    // hit on word 3
    req_valid = 1'b1;
    req_addr = 32'h13;
    tick();
    req_valid = 1'b0;
    #1;
    chk("hit_rv", resp_valid, 1);
    chk("hit_ins", resp_instr, 32'hDDDD0003);
    chk("hit_mreq_v", mem_req_valid, 0);
    tick();
    chk("hit_idle_rv", resp_valid, 0);
    chk("hit_idle_rdy", req_ready, 1);

    // conflict on set 4
    do_miss(32'h110, LINE2, 32'h1111000A, "conf");

    // re-request evicted line with request backpressure
    mem_req_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 32'h12;
    tick();
    req_valid = 1'b0;
    #1;
    chk("bp_lookup_rv", resp_valid, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_mreq_v", mem_req_valid, 1);
      chk("bp_mreq_a", mem_req_addr, 32'h10);
      chk("bp_rv", resp_valid, 0);
    end
    mem_req_ready = 1'b1;
    tick();
    chk("bp_wait_mreq_v", mem_req_valid, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data = LINE1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("bp_refill_rv", resp_valid, 1);
    chk("bp_refill_ins", resp_instr, 32'hCCCC0002);
    tick();

    // flush during MEM_WAIT
    req_valid = 1'b1;
    req_addr = 32'h20;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    #1;
    chk("fl_rdy_flush", req_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_rdy_pend", req_ready, 0);
    mem_resp_valid = 1'b1;
    mem_resp_data = LINE3;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("fl_refill_rv", resp_valid, 1);
    chk("fl_refill_ins", resp_instr, 32'h90000000);
    chk("fl_refill_rdy", req_ready, 0);
    tick();
    chk("fl_idle_rdy", req_ready, 1);
    do_miss(32'h21, LINE3, 32'h90000001, "fl_again");
    do_miss(32'h13, LINE1, 32'hDDDD0003, "fl_other");

    // reset during MEM_WAIT, late memory response
    req_valid = 1'b1;
    req_addr = 32'h30;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = LINE4;
    #1;
    chk("rm_rdy", req_ready, 1);
    chk("rm_rv", resp_valid, 0);
    chk("rm_ins", resp_instr, 0);
    chk("rm_mreq_v", mem_req_valid, 0);
`ifdef ICACHE_PERF_CNT_EN
    chk("rm_hits", hit_count, 0);
    chk("rm_misses", miss_count, 0);
`endif
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("rm_late_rv", resp_valid, 0);
    do_miss(32'h32, LINE4, 32'h70000002, "rm_again");
`ifdef ICACHE_PERF_CNT_EN
    chk("rm_misses_after", miss_count, 1);
    chk("rm_hits_after", hit_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
